// File: rtl/pwm_led_pkg.sv
// Shared widths and pin-field indices for the pwm_led slice.
// Optional build macro used by the top: PWM_BREATHE_EN (triangle breathe source).
package pwm_led_pkg;
  localparam int CNT_W  = 8;
  localparam int PSEL_W = 4;
  localparam int PRE_W  = 15;

  // uio_in fields
  localparam int P_LSB    = 0;
  localparam int INV_BIT  = 4;
  localparam int HOLD_BIT = 5;
  localparam int BRTH_BIT = 6;

  // uo_out fields
  localparam int UO_PWM     = 0;
  localparam int UO_PWM_N   = 1;
  localparam int UO_WRAP    = 2;
  localparam int UO_TICK    = 3;
  localparam int UO_CNT_LSB = 4;
endpackage

// File: rtl/pwm_led_top_prescaler.sv
// Power-of-two prescaler: tick when pre_cnt reaches 2^sel - 1, then restart.
// Frozen (and tick suppressed) while hold is high.
module pwm_prescaler
  import pwm_led_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [PSEL_W-1:0] sel,
  output logic              tick
);

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] term;

  // >= rather than == so a shrinking divide ratio cannot strand the counter
  assign term = ~({PRE_W{1'b1}} << sel);
  assign tick = !hold && (pre_cnt >= term);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!hold) begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/pwm_led_top.sv
// TinyTapeout 8-bit PWM LED driver: period counter, wrap-latched duty, registered outputs.
// Build option: define PWM_BREATHE_EN to add the triangle (breathe) duty source on uio_in[6].
module pwm_led_top
  import pwm_led_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] duty_src;
  logic             pwm_q;
  logic             wrap_q;
  logic             tick_q;
  logic             tick;
  logic             wrap;
  logic             inv;
  logic             hold;

  assign inv  = uio_in[INV_BIT];
  assign hold = uio_in[HOLD_BIT];
  assign wrap = tick && (cnt == '1);

  pwm_prescaler u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .sel   (uio_in[P_LSB +: PSEL_W]),
    .tick  (tick)
  );

`ifdef PWM_BREATHE_EN
  logic [CNT_W-1:0] tri_q;
  logic             tri_up;
  logic             unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in[7]};
  assign duty_src  = uio_in[BRTH_BIT] ? tri_q : ui_in;

  // Turn around at the ends so each extreme is held for exactly one period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tri_q  <= '0;
      tri_up <= 1'b1;
    end else if (wrap) begin
      if (tri_up && tri_q == '1) begin
        tri_up <= 1'b0;
        tri_q  <= tri_q - CNT_W'(1);
      end else if (!tri_up && tri_q == '0) begin
        tri_up <= 1'b1;
        tri_q  <= tri_q + CNT_W'(1);
      end else begin
        tri_q  <= tri_up ? tri_q + CNT_W'(1) : tri_q - CNT_W'(1);
      end
    end
  end
`else
  logic unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in[7:6]};
  assign duty_src  = ui_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      wrap_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end
      // Duty only changes at the period boundary, so mid-period writes never glitch
      if (wrap) begin
        duty_q <= duty_src;
      end
      pwm_q  <= (cnt < duty_q) ^ inv;
      wrap_q <= wrap;
      tick_q <= tick;
    end
  end

  assign uo_out  = {cnt[CNT_W-1 -: 4], tick_q, wrap_q, ~pwm_q, pwm_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_pwm_led_top.sv
// Directed bench for pwm_led_top: per-period vector table plus hand-written corner sequences.
module tb_pwm_led_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_led_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  typedef struct {
    logic [7:0] duty;
    logic [3:0] psel;
    logic       inv;
    int         exp_per;
    int         exp_high;
    int         exp_ticks;
    int         exp_rises;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] d, input logic [7:0] uio);
    ui_in  = d;
    uio_in = uio;
    rst_n  = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
  endtask

  task automatic wait_wrap(input string name, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!uo_out[2] && n < 5000);
    if (!uo_out[2]) check({name, "_timeout"}, 0, 1);
  endtask

  // Starts on a sample showing wrap; accumulates one full period up to the next wrap.
  task automatic measure(input int chg_at, input logic [7:0] chg_duty,
                         output int per, output int high, output int ticks,
                         output int rises, output int cerr);
    logic prev;
    prev = 1'b0;
    per = 0; high = 0; ticks = 0; rises = 0; cerr = 0;
    do begin
      if (per == chg_at) ui_in = chg_duty;
      high  += int'(uo_out[0]);
      ticks += int'(uo_out[3]);
      if (uo_out[0] && !prev) rises++;
      if (uo_out[1] == uo_out[0]) cerr++;
      prev = uo_out[0];
      step();
      per++;
    end while (!uo_out[2] && per < 5000);
  endtask

  initial begin
    int per, high, ticks, rises, cerr, n;
    logic [3:0] cnt_frz;
    int bad_frz, bad_wrap;

    vecs[0] = '{8'd64,  4'd0, 1'b0, 256,  64,  256, 1};
    vecs[1] = '{8'd0,   4'd0, 1'b0, 256,  0,   256, 0};
    vecs[2] = '{8'd255, 4'd0, 1'b0, 256,  255, 256, 1};
    vecs[3] = '{8'd128, 4'd2, 1'b0, 1024, 512, 256, 1};
    vecs[4] = '{8'd64,  4'd0, 1'b1, 256,  192, 256, 2};
    vecs[5] = '{8'd1,   4'd1, 1'b0, 512,  2,   256, 1};

    ena = 1'b1; ui_in = 8'd0; uio_in = 8'd0; rst_n = 1'b0;
    step(); step();
    check("reset_uo_out", int'(uo_out), 8'h02);
    check("uio_out_uio_oe", int'({uio_out, uio_oe}), 0);

    // First period after reset runs at duty 0 and ends with one wrap
    do_reset(8'd64, 8'h00);
    high = 0; n = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      high += int'(uo_out[0]);
      n    += int'(uo_out[2]);
    end
    check("first_period_high", high, 0);
    check("first_period_wraps", n, 1);
    check("first_wrap_last", int'(uo_out[2]), 1);

    for (int v = 0; v < 6; v++) begin
      do_reset(vecs[v].duty, {3'b000, vecs[v].inv, vecs[v].psel});
      wait_wrap($sformatf("v%0d_wrap", v), n);
      measure(-1, 8'd0, per, high, ticks, rises, cerr);
      check($sformatf("v%0d_period", v), per, vecs[v].exp_per);
      check($sformatf("v%0d_high", v), high, vecs[v].exp_high);
      check($sformatf("v%0d_ticks", v), ticks, vecs[v].exp_ticks);
      check($sformatf("v%0d_rises", v), rises, vecs[v].exp_rises);
      check($sformatf("v%0d_compl", v), cerr, 0);
    end

    // Mid-period duty change only takes effect after the next wrap
    do_reset(8'd64, 8'h00);
    wait_wrap("chg_wrap", n);
    measure(100, 8'd200, per, high, ticks, rises, cerr);
    check("chg_cur_high", high, 64);
    measure(-1, 8'd0, per, high, ticks, rises, cerr);
    check("chg_next_high", high, 200);

    // Prescaler select shrinks below the current count: immediate tick
    do_reset(8'd0, 8'h04);
    for (int i = 0; i < 10; i++) step();
    check("psel_pre_tick", int'(uo_out[3]), 0);
    uio_in = 8'h02;
    step();
    check("psel_shrink_tick", int'(uo_out[3]), 1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n += int'(uo_out[3]);
    end
    check("psel_next_tick_count", n, 1);
    check("psel_next_tick_pos", int'(uo_out[3]), 1);

    // HOLD freezes the counter mid-period; resuming finishes the period
    do_reset(8'd64, 8'h00);
    wait_wrap("hold_wrap", n);
    for (int i = 0; i < 30; i++) step();
    check("hold_cnt_before", int'(uo_out[7:4]), 1);
    cnt_frz = uo_out[7:4];
    uio_in = 8'h20;
    bad_frz = 0; bad_wrap = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (uo_out[7:4] != cnt_frz) bad_frz++;
      if (uo_out[2]) bad_wrap++;
    end
    check("hold_cnt_frozen", bad_frz, 0);
    check("hold_no_wrap", bad_wrap, 0);
    uio_in = 8'h00;
    wait_wrap("hold_resume", n);
    check("hold_resume_steps", n, 226);

    // Reset mid-period returns to the reset state and restarts the counter
    for (int i = 0; i < 150; i++) step();
    rst_n = 1'b0;
    step();
    check("midreset_uo_out", int'(uo_out), 8'h02);
    rst_n = 1'b1;
    step();
    check("midreset_first_tick", int'(uo_out), 8'h0A);
    wait_wrap("midreset_wrap", n);
    check("midreset_wrap_steps", n, 255);

`ifdef PWM_BREATHE_EN
    do_reset(8'd7, 8'h40);
    wait_wrap("brth_wrap", n);
    for (int k = 0; k < 4; k++) begin
      measure(-1, 8'd0, per, high, ticks, rises, cerr);
      check($sformatf("brth_high_%0d", k), high, k);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
